// File: rtl/input_event_queue_if.sv
// input_event_queue_if: button/pop/status bundle between debouncer, game logic and the event queue
// Ports:
//   btn_left/btn_right/btn_rotate/btn_down  one-cycle button request pulses
//   rd_en      pop strobe from game logic
//   clr_ovf    clears the sticky overflow flag
//   evt_valid  queue non-empty, evt_code holds the head
//   evt_code   head event: 00 left, 01 right, 10 rotate, 11 down
//   count      current occupancy
//   overflow   sticky event-lost flag
interface input_event_queue_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_rotate;
    logic       btn_down;
    logic       rd_en;
    logic       clr_ovf;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [2:0] count;
    logic       overflow;
    modport master (
        output btn_left, btn_right, btn_rotate, btn_down, rd_en, clr_ovf,
        input  evt_valid, evt_code, count, overflow
    );
    modport slave (
        input  btn_left, btn_right, btn_rotate, btn_down, rd_en, clr_ovf,
        output evt_valid, evt_code, count, overflow
    );
endinterface

// File: rtl/input_event_queue.sv
// input_event_queue: latches button pulses into pending bits and arbitrates them into a show-ahead FIFO
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    input_event_queue_if.slave: button pulses, rd_en, clr_ovf in; evt_valid, evt_code, count, overflow out
module input_event_queue #(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    input_event_queue_if.slave bus
);
    logic [3:0] btn, grant, pend_q, pend_d;
    logic [2:0] wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
    logic       ovf_q, ovf_d, push, pop;
    logic [1:0] code;
    // Eight slots so a 3-bit pointer indexes exactly; only DEPTH are used.
    logic [1:0] mem_q [8];

    always_comb begin
        btn    = {bus.btn_down, bus.btn_rotate, bus.btn_right, bus.btn_left};
        pop    = bus.rd_en && cnt_q != 3'd0;
        push   = |pend_q && (cnt_q < 3'(DEPTH) || pop);
        code   = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
        grant  = push ? 4'b0001 << code : 4'b0000;
        // A pulse on the bit being transferred simply re-arms it.
        pend_d = (pend_q & ~grant) | btn;
        ovf_d  = |(btn & pend_q & ~grant) || (ovf_q && !bus.clr_ovf);
        wp_d   = push ? (wp_q == 3'(DEPTH - 1) ? 3'd0 : wp_q + 3'd1) : wp_q;
        rp_d   = pop ? (rp_q == 3'(DEPTH - 1) ? 3'd0 : rp_q + 3'd1) : rp_q;
        cnt_d  = cnt_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0;
            wp_q   <= 3'd0;
            rp_q   <= 3'd0;
            cnt_q  <= 3'd0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= code;
    end

    assign bus.evt_valid = cnt_q != 3'd0;
    assign bus.evt_code  = bus.evt_valid ? mem_q[rp_q] : 2'b00;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_input_event_queue.sv
// tb_input_event_queue: directed self-checking bench for input_event_queue
module tb_input_event_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    input_event_queue_if bus ();

    input_event_queue #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic btns(input logic [3:0] b);
        {bus.btn_down, bus.btn_rotate, bus.btn_right, bus.btn_left} = b;
    endtask

    task automatic pulse(input logic [3:0] b);
        btns(b);
        tick();
        btns(4'b0);
    endtask

    task automatic pop_check(input string tag, input logic [1:0] exp);
        check({tag, "_valid"}, {7'b0, bus.evt_valid}, 8'd1);
        check({tag, "_code"}, {6'b0, bus.evt_code}, {6'b0, exp});
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    logic [1:0] wrap_seq [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd1};

    initial begin
        btns(4'b0);
        bus.rd_en = 1'b0;
        bus.clr_ovf = 1'b0;
        #1;
        check("rst_valid", {7'b0, bus.evt_valid}, 8'd0);
        check("rst_code", {6'b0, bus.evt_code}, 8'd0);
        check("rst_count", {5'b0, bus.count}, 8'd0);
        check("rst_ovf", {7'b0, bus.overflow}, 8'd0);
        btns(4'b1111);
        tick();
        tick();
        btns(4'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_ignore", {5'b0, bus.count}, 8'd0);

        pulse(4'b0100);
        check("single_pend", {7'b0, bus.evt_valid}, 8'd0);
        tick();
        check("single_valid", {7'b0, bus.evt_valid}, 8'd1);
        check("single_code", {6'b0, bus.evt_code}, 8'd2);
        check("single_count", {5'b0, bus.count}, 8'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("single_empty", {5'b0, bus.count}, 8'd0);

        bus.rd_en = 1'b1;
        pulse(4'b1101);
        check("sim_e0", {5'b0, bus.count}, 8'd0);
        tick();
        check("sim_c0", {6'b0, bus.evt_code}, 8'd0);
        tick();
        check("sim_c1", {6'b0, bus.evt_code}, 8'd2);
        check("sim_cnt", {5'b0, bus.count}, 8'd1);
        tick();
        check("sim_c2", {6'b0, bus.evt_code}, 8'd3);
        tick();
        bus.rd_en = 1'b0;
        check("sim_empty", {7'b0, bus.evt_valid}, 8'd0);
        check("sim_ovf", {7'b0, bus.overflow}, 8'd0);

        pulse(4'b0001);
        pulse(4'b0010);
        pulse(4'b0100);
        pulse(4'b1000);
        pulse(4'b0010);
        tick();
        check("full_count", {5'b0, bus.count}, 8'd4);
        check("full_head", {6'b0, bus.evt_code}, 8'd0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("full_refill", {5'b0, bus.count}, 8'd4);
        check("full_head2", {6'b0, bus.evt_code}, 8'd1);
        check("full_ovf", {7'b0, bus.overflow}, 8'd0);

        pulse(4'b0001);
        check("ovf_pend", {7'b0, bus.overflow}, 8'd0);
        pulse(4'b0001);
        check("ovf_set", {7'b0, bus.overflow}, 8'd1);
        tick();
        check("ovf_hold", {7'b0, bus.overflow}, 8'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_clr", {7'b0, bus.overflow}, 8'd0);
        bus.clr_ovf = 1'b1;
        pulse(4'b0001);
        bus.clr_ovf = 1'b0;
        check("ovf_clr_drop", {7'b0, bus.overflow}, 8'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_clr2", {7'b0, bus.overflow}, 8'd0);

        bus.rd_en = 1'b1;
        pulse(4'b0001);
        check("rearm_ovf", {7'b0, bus.overflow}, 8'd0);
        check("rearm_count", {5'b0, bus.count}, 8'd4);
        tick();
        bus.rd_en = 1'b0;
        check("rearm_count2", {5'b0, bus.count}, 8'd4);
        pop_check("drain0", 2'd3);
        pop_check("drain1", 2'd1);
        pop_check("drain2", 2'd0);
        pop_check("drain3", 2'd0);
        check("drain_empty", {7'b0, bus.evt_valid}, 8'd0);
        check("drain_code", {6'b0, bus.evt_code}, 8'd0);
        check("drain_ovf", {7'b0, bus.overflow}, 8'd0);

        for (int i = 0; i < 10; i++) begin
            pulse(4'b0001 << wrap_seq[i]);
            tick();
            check($sformatf("wrap%0d_cnt", i), {5'b0, bus.count}, 8'd1);
            pop_check($sformatf("wrap%0d", i), wrap_seq[i]);
            check($sformatf("wrap%0d_empty", i), {5'b0, bus.count}, 8'd0);
        end

        btns(4'b0011);
        tick();
        btns(4'b0010);
        tick();
        btns(4'b0000);
        check("drop_ovf", {7'b0, bus.overflow}, 8'd1);
        tick();
        pulse(4'b0100);
        tick();
        check("ar_count", {5'b0, bus.count}, 8'd3);
        check("ar_ovf", {7'b0, bus.overflow}, 8'd1);
        check("ar_code", {6'b0, bus.evt_code}, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {7'b0, bus.evt_valid}, 8'd0);
        check("ar_count0", {5'b0, bus.count}, 8'd0);
        check("ar_ovf0", {7'b0, bus.overflow}, 8'd0);
        check("ar_code0", {6'b0, bus.evt_code}, 8'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("ar_after", {5'b0, bus.count}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
